sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller command port between two requesters. One is the TFT display-refresh line fetcher (burst reads of the shown page). The other is the user write path (single-word writes from the one-entry user FIFO at the current window row/column of the set page). Reads get priority to protect display timing. A starvation guard bounds write latency. Only one command is outstanding at a time, and read data is routed back to the fetcher.

---
 rtl/tft_sdram_pkg.sv | 33 +++
 rtl/sdram_beat_cnt.sv | 36 +++
 rtl/sdram_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_sdram_pkg
// Brief    : Shared arbiter state encoding, SDRAM address fields, TFT limits.
// Revision : 1.0 - initial release
// ============================================================================
package tft_sdram_pkg;

    localparam int PAGE_W = 3;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;
    localparam int PACK_W = PAGE_W + ROW_W + COL_W;

    localparam int TFT_ROWS = 480;
    localparam int TFT_COLS = 800;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_WR_ISSUE = 2'd3
    } arb_state_t;

    function automatic logic [PACK_W-1:0] pack_addr(
        input logic [PAGE_W-1:0] page,
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col
    );
        return {page, row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : sdram_beat_cnt
// Brief    : Read-burst beat counter with terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_beat_cnt #(
    parameter int BURST_LEN = 8
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    localparam int                 c_CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BURST_LEN - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // High while the next beat to arrive is the final one of the burst.
    assign o_last = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : Shares the SDRAM command port between display reads and user writes.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import tft_sdram_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 22
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              rd_req,
    input  logic [2:0]        rd_page,
    input  logic [8:0]        rd_row,
    input  logic [9:0]        rd_col,
    output logic              rd_ack,
    output logic [15:0]       rd_data,
    output logic              rd_data_valid,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [2:0]        wr_page,
    input  logic [8:0]        wr_row,
    input  logic [9:0]        wr_col,
    input  logic [15:0]       wr_data,
    output logic              wr_ack,
    output logic              sd_cmd_valid,
    input  logic              sd_cmd_ready,
    output logic              sd_cmd_we,
    output logic [ADDR_W-1:0] sd_cmd_addr,
    output logic [7:0]        sd_cmd_len,
    output logic [15:0]       sd_wdata,
    input  logic [15:0]       sd_rdata,
    input  logic              sd_rdata_valid,
    output logic              busy
);

    localparam int                    c_STARVE_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);
    // A 256-beat burst wraps to 0 in the 8-bit length field.
    localparam logic [7:0]            c_RD_LEN     = 8'(BURST_LEN);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic                  w_rd_grant;
    logic                  w_wr_grant;
    logic                  w_beat;
    logic                  w_beat_clr;
    logic                  w_beat_last;
    logic [c_STARVE_W-1:0] r_starve;

    logic                  r_cmd_we;
    logic [ADDR_W-1:0]     r_cmd_addr;
    logic [7:0]            r_cmd_len;
    logic [15:0]           r_wdata;
    logic [15:0]           r_rd_data;
    logic                  r_rd_data_valid;
    logic                  r_rd_done;

    assign w_beat = (r_state == ST_RD_WAIT) && sd_rdata_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_grant  = 1'b0;
        w_wr_grant  = 1'b0;
        w_beat_clr  = 1'b0;
        rd_ack      = 1'b0;
        wr_ack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wr_req && ((r_starve == c_STARVE_MAX) || !rd_req)) begin
                    w_wr_grant  = 1'b1;
                    w_state_nxt = ST_WR_ISSUE;
                end else if (rd_req) begin
                    w_rd_grant  = 1'b1;
                    w_state_nxt = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                if (sd_cmd_ready) begin
                    rd_ack      = 1'b1;
                    w_beat_clr  = 1'b1;
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (w_beat && w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_ISSUE: begin
                if (sd_cmd_ready) begin
                    wr_ack      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write priority rises only while a write is actually waiting behind reads.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_starve <= '0;
        end else if (!wr_req || w_wr_grant) begin
            r_starve <= '0;
        end else if (w_rd_grant && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + c_STARVE_W'(1);
        end
    end

    // Command fields are captured at grant so they stay frozen through a stall.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cmd_we   <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_wdata    <= '0;
        end else if (w_rd_grant) begin
            r_cmd_we   <= 1'b0;
            r_cmd_addr <= ADDR_W'(pack_addr(rd_page, rd_row, rd_col));
            r_cmd_len  <= c_RD_LEN;
            r_wdata    <= '0;
        end else if (w_wr_grant) begin
            r_cmd_we   <= 1'b1;
            r_cmd_addr <= ADDR_W'(pack_addr(wr_page, wr_row, wr_col));
            r_cmd_len  <= 8'd1;
            r_wdata    <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
            r_rd_done       <= 1'b0;
        end else begin
            r_rd_data_valid <= w_beat;
            r_rd_done       <= w_beat && w_beat_last;
            if (w_beat) begin
                r_rd_data <= sd_rdata;
            end
        end
    end

    sdram_beat_cnt #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .i_clr  (w_beat_clr),
        .i_inc  (w_beat),
        .o_last (w_beat_last)
    );

    assign sd_cmd_valid  = (r_state == ST_RD_ISSUE) || (r_state == ST_WR_ISSUE);
    assign sd_cmd_we     = r_cmd_we;
    assign sd_cmd_addr   = r_cmd_addr;
    assign sd_cmd_len    = r_cmd_len;
    assign sd_wdata      = r_wdata;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_data_valid;
    assign rd_done       = r_rd_done;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Brief    : Directed self-checking bench for sdram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rd_req = 1'b0;
    logic [2:0]  rd_page = '0;
    logic [8:0]  rd_row = '0;
    logic [9:0]  rd_col = '0;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;
    logic        wr_req = 1'b0;
    logic [2:0]  wr_page = '0;
    logic [8:0]  wr_row = '0;
    logic [9:0]  wr_col = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        sd_cmd_valid;
    logic        sd_cmd_ready = 1'b0;
    logic        sd_cmd_we;
    logic [21:0] sd_cmd_addr;
    logic [7:0]  sd_cmd_len;
    logic [15:0] sd_wdata;
    logic [15:0] sd_rdata = '0;
    logic        sd_rdata_valid = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .BURST_LEN  (8),
        .STARVE_MAX (4),
        .ADDR_W     (22)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .rd_req         (rd_req),
        .rd_page        (rd_page),
        .rd_row         (rd_row),
        .rd_col         (rd_col),
        .rd_ack         (rd_ack),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .rd_done        (rd_done),
        .wr_req         (wr_req),
        .wr_page        (wr_page),
        .wr_row         (wr_row),
        .wr_col         (wr_col),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .sd_cmd_valid   (sd_cmd_valid),
        .sd_cmd_ready   (sd_cmd_ready),
        .sd_cmd_we      (sd_cmd_we),
        .sd_cmd_addr    (sd_cmd_addr),
        .sd_cmd_len     (sd_cmd_len),
        .sd_wdata       (sd_wdata),
        .sd_rdata       (sd_rdata),
        .sd_rdata_valid (sd_rdata_valid),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Event log taken on the falling edge, away from register updates.
    int   n_rd_ack = 0;
    int   n_wr_ack = 0;
    int   n_dv     = 0;
    int   n_done   = 0;
    logic grant_we[$];

    always @(negedge clk) begin
        if (nrst) begin
            if (sd_cmd_valid && sd_cmd_ready) grant_we.push_back(sd_cmd_we);
            if (rd_ack)        n_rd_ack++;
            if (wr_ack)        n_wr_ack++;
            if (rd_data_valid) n_dv++;
            if (rd_done)       n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic issue_read(input logic [2:0] pg, input logic [8:0] rw, input logic [9:0] cl,
                              input int stall, input logic [21:0] exp_addr, input string tag);
        rd_page = pg; rd_row = rw; rd_col = cl;
        rd_req = 1'b1; sd_cmd_ready = 1'b0;
        tick();
        check({tag, "_valid"}, sd_cmd_valid, 1'b1);
        check({tag, "_we"},    sd_cmd_we, 1'b0);
        check({tag, "_len"},   sd_cmd_len, 8'd8);
        check({tag, "_addr"},  sd_cmd_addr, exp_addr);
        rd_page = ~pg; rd_col = cl ^ 10'd1;
        repeat (stall) tick();
        check({tag, "_addr_hold"}, sd_cmd_addr, exp_addr);
        sd_cmd_ready = 1'b1;
        #1;
        check({tag, "_rd_ack"}, rd_ack, 1'b1);
        tick();
        rd_req = 1'b0; sd_cmd_ready = 1'b0;
        check({tag, "_busy_wait"}, busy, 1'b1);
    endtask

    task automatic collect_beats(input logic [15:0] base, input string tag);
        for (int i = 0; i < 8; i++) begin
            sd_rdata_valid = 1'b1;
            sd_rdata = base + 16'(i);
            tick();
            check({tag, "_dv"},   rd_data_valid, 1'b1);
            check({tag, "_data"}, rd_data, base + 16'(i));
            check({tag, "_done"}, rd_done, (i == 7));
            if (i == 3) begin
                sd_rdata_valid = 1'b0;
                tick();
                check({tag, "_gap_dv"}, rd_data_valid, 1'b0);
            end
        end
        sd_rdata_valid = 1'b0;
        check({tag, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int a0, d0, v0, w0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  busy, 1'b0);
        check("rst_valid", sd_cmd_valid, 1'b0);
        check("rst_addr",  sd_cmd_addr, 22'h0);
        check("rst_len",   sd_cmd_len, 8'h0);
        check("rst_rdata", rd_data, 16'h0);
        nrst = 1'b1;
        tick();

        // Read only: page 2, row 10, col 0 -> 2<<19 | 10<<10 = 0x102800
        a0 = n_rd_ack; d0 = n_done; v0 = n_dv;
        issue_read(3'd2, 9'd10, 10'd0, 3, 22'h102800, "rd");
        collect_beats(16'hA000, "rd");
        tick();
        check("rd_ack_count",  n_rd_ack - a0, 1);
        check("rd_done_count", n_done - d0, 1);
        check("rd_dv_count",   n_dv - v0, 8);

        // Stray beat in IDLE
        v0 = n_dv;
        sd_rdata_valid = 1'b1; sd_rdata = 16'hDEAD;
        tick();
        check("stray_idle_dv", rd_data_valid, 1'b0);
        sd_rdata_valid = 1'b0;

        // Write only: page 1, row 479, col 799 -> 0xF7F1F, stalled 5 cycles
        w0 = n_wr_ack;
        wr_page = 3'd1; wr_row = 9'd479; wr_col = 10'd799; wr_data = 16'hF800;
        wr_req = 1'b1; sd_cmd_ready = 1'b0;
        tick();
        wr_col = 10'd0; wr_data = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            sd_rdata_valid = (i == 2);
            check("wr_valid_hold", sd_cmd_valid, 1'b1);
            check("wr_addr_hold",  sd_cmd_addr, 22'hF7F1F);
            check("wr_data_hold",  sd_wdata, 16'hF800);
            check("wr_no_ack",     wr_ack, 1'b0);
            tick();
        end
        sd_rdata_valid = 1'b0;
        check("stray_wr_dv", n_dv - v0, 0);
        sd_cmd_ready = 1'b1;
        #1;
        check("wr_ack", wr_ack, 1'b1);
        check("wr_we",  sd_cmd_we, 1'b1);
        check("wr_len", sd_cmd_len, 8'd1);
        tick();
        wr_req = 1'b0; sd_cmd_ready = 1'b0;
        check("wr_idle_after", busy, 1'b0);
        tick();
        check("wr_ack_count", n_wr_ack - w0, 1);
        check("stray_done", n_done - d0, 1);

        // Starvation: both requests held, controller always ready and streaming
        grant_we.delete();
        sd_cmd_ready = 1'b1; sd_rdata_valid = 1'b1; sd_rdata = 16'h1234;
        rd_req = 1'b1; wr_req = 1'b1;
        repeat (90) tick();
        rd_req = 1'b0; wr_req = 1'b0;
        wait_idle("starve_idle");
        sd_rdata_valid = 1'b0; sd_cmd_ready = 1'b0;
        tick();
        check("starve_ngrants", grant_we.size() >= 10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i < grant_we.size()) check("starve_order", grant_we[i], (i == 4 || i == 9));
        end

        // Simultaneous request from starve=0: read wins, write follows
        sd_cmd_ready = 1'b1;
        rd_req = 1'b1; wr_req = 1'b1;
        tick();
        check("sim_first_valid", sd_cmd_valid, 1'b1);
        check("sim_first_we",    sd_cmd_we, 1'b0);
        rd_req = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            sd_rdata_valid = 1'b1;
            tick();
        end
        sd_rdata_valid = 1'b0;
        check("sim_gap_idle", busy, 1'b0);
        tick();
        check("sim_second_valid", sd_cmd_valid, 1'b1);
        check("sim_second_we",    sd_cmd_we, 1'b1);
        wr_req = 1'b0;
        tick();
        sd_cmd_ready = 1'b0;
        wait_idle("sim_idle");

        // Reset mid-burst after beat 3 of 8: page 3 -> 0x180000
        d0 = n_done;
        issue_read(3'd3, 9'd0, 10'd0, 0, 22'h180000, "rb");
        for (int i = 0; i < 3; i++) begin
            sd_rdata_valid = 1'b1; sd_rdata = 16'h5500 + 16'(i);
            tick();
        end
        sd_rdata = 16'h55FF;
        #1 nrst = 1'b0;
        #1;
        check("rb_dv",    rd_data_valid, 1'b0);
        check("rb_data",  rd_data, 16'h0);
        check("rb_busy",  busy, 1'b0);
        check("rb_addr",  sd_cmd_addr, 22'h0);
        check("rb_done",  rd_done, 1'b0);
        tick();
        nrst = 1'b1; sd_rdata_valid = 1'b0;
        tick();
        check("rb_no_done", n_done - d0, 0);

        // Fresh burst after reset: page 0, row 479, col 16 -> 0x77C10
        issue_read(3'd0, 9'd479, 10'd16, 1, 22'h77C10, "rn");
        collect_beats(16'h7700, "rn");
        tick();
        check("rn_done_count", n_done - d0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
